// File: rtl/multi_ball_pkg.sv
// Shared types and arithmetic helpers for the multi-ball motion engine.
// Object fields are fixed at 10-bit position / 10-bit signed velocity here.
package multi_ball_pkg;

  localparam int OBJ_POS_W = 10;
  localparam int OBJ_VEL_W = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WAIT,
    S_UPDATE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic        [OBJ_POS_W-1:0] x;
    logic        [OBJ_POS_W-1:0] y;
    logic signed [OBJ_VEL_W-1:0] vx;
    logic signed [OBJ_VEL_W-1:0] vy;
  } obj_state_t;

  typedef logic signed [OBJ_POS_W+1:0] pos_ext_t;
  typedef logic signed [OBJ_VEL_W:0]   vel_ext_t;

  function automatic logic [OBJ_POS_W-1:0] saturate_pos(input pos_ext_t p, input int limit);
    if (p < 0) return '0;
    else if (p >= pos_ext_t'(limit)) return OBJ_POS_W'(limit - 1);
    else return p[OBJ_POS_W-1:0];
  endfunction

  function automatic logic signed [OBJ_VEL_W-1:0] clamp_vel(input vel_ext_t v, input int lim);
    if (v > vel_ext_t'(lim)) return OBJ_VEL_W'(lim);
    else if (v < -vel_ext_t'(lim)) return -(OBJ_VEL_W'(lim));
    else return v[OBJ_VEL_W-1:0];
  endfunction

  // Moves v toward zero by decel, snapping to zero instead of crossing it.
  function automatic vel_ext_t apply_friction(input vel_ext_t v, input int decel);
    vel_ext_t d;
    d = vel_ext_t'(decel);
    if (v <= d && v >= -d) return '0;
    else if (v > 0) return v - d;
    else return v + d;
  endfunction

endpackage

// File: rtl/ball_integrator.sv
// Combinational single-object step: bounce, integrate, edge saturate, buttons, friction, clamp.
// Friction stage exists only when MULTI_BALL_FRICTION_EN is defined.
module ball_integrator
  import multi_ball_pkg::*;
#(
  parameter int SCREEN_W  = 800,
  parameter int SCREEN_H  = 600,
  parameter int MAX_SPEED = 10,
  parameter int DECEL     = 1
) (
  input  obj_state_t cur,
  input  logic       coll_x,
  input  logic       coll_y,
  input  logic       player,
  input  logic       button_u,
  input  logic       button_d,
  input  logic       button_l,
  input  logic       button_r,
`ifdef MULTI_BALL_FRICTION_EN
  input  logic       fric,
`endif
  output obj_state_t nxt
);

  vel_ext_t vx_b, vy_b, vx_e, vy_e;
  pos_ext_t x_sum, y_sum;

  always_comb begin
    vx_b  = coll_x ? -vel_ext_t'(cur.vx) : vel_ext_t'(cur.vx);
    vy_b  = coll_y ? -vel_ext_t'(cur.vy) : vel_ext_t'(cur.vy);
    x_sum = pos_ext_t'({2'b00, cur.x}) + pos_ext_t'(vx_b);
    y_sum = pos_ext_t'({2'b00, cur.y}) + pos_ext_t'(vy_b);

    nxt   = cur;
    nxt.x = saturate_pos(x_sum, SCREEN_W);
    nxt.y = saturate_pos(y_sum, SCREEN_H);
    vx_e  = (x_sum < 0 || x_sum >= pos_ext_t'(SCREEN_W)) ? -vx_b : vx_b;
    vy_e  = (y_sum < 0 || y_sum >= pos_ext_t'(SCREEN_H)) ? -vy_b : vy_b;

    // Opposing buttons cancel; only the player object listens.
    if (player) begin
      if (button_r && !button_l) vx_e = vx_e + vel_ext_t'(1);
      if (button_l && !button_r) vx_e = vx_e - vel_ext_t'(1);
      if (button_d && !button_u) vy_e = vy_e + vel_ext_t'(1);
      if (button_u && !button_d) vy_e = vy_e - vel_ext_t'(1);
    end

`ifdef MULTI_BALL_FRICTION_EN
    if (fric) begin
      vx_e = apply_friction(vx_e, DECEL);
      vy_e = apply_friction(vy_e, DECEL);
    end
`endif

    nxt.vx = clamp_vel(vx_e, MAX_SPEED);
    nxt.vy = clamp_vel(vy_e, MAX_SPEED);
  end

endmodule

// File: rtl/multi_ball_physics.sv
// Per-frame motion engine walking N_OBJ balls through map lookup and one shared integrator.
// Optional friction is enabled by defining MULTI_BALL_FRICTION_EN.
//
// state    | meaning
// IDLE     | waiting for frame_tick
// LOOKUP   | coll_addr driven for object idx
// WAIT     | COLL_LAT-cycle map latency, address held
// UPDATE   | integrator result written to object idx
// DONE     | update_done pulse, back to IDLE
module multi_ball_physics
  import multi_ball_pkg::*;
#(
  parameter int N_OBJ        = 4,
  parameter int SCREEN_W     = 800,
  parameter int SCREEN_H     = 600,
  parameter int POS_W        = OBJ_POS_W,
  parameter int VEL_W        = OBJ_VEL_W,
  parameter int ADDR_W       = 19,
  parameter int MAX_SPEED    = 10,
  parameter int DECEL        = 1,
  parameter int DECEL_PERIOD = 5,
  parameter int COLL_LAT     = 1,
  parameter int INIT_X       = 200,
  parameter int INIT_Y       = 300,
  parameter int INIT_STEP    = 40,
  parameter int INIT_VX      = 2,
  parameter int INIT_VY      = 1
) (
  input  logic                   pixel_clk,
  input  logic                   rst,
  input  logic                   frame_tick,
  input  logic                   button_u,
  input  logic                   button_d,
  input  logic                   button_l,
  input  logic                   button_r,
  output logic [ADDR_W-1:0]      coll_addr,
  input  logic                   coll_x,
  input  logic                   coll_y,
  output logic [N_OBJ*POS_W-1:0] obj_x,
  output logic [N_OBJ*POS_W-1:0] obj_y,
  output logic                   busy,
  output logic                   update_done,
  output logic                   frame_overrun
);

  localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [2:0]       wait_cnt;
  logic             coll_x_q, coll_y_q;
  obj_state_t       obj [N_OBJ];
  obj_state_t       cur, upd;

`ifdef MULTI_BALL_FRICTION_EN
  localparam int FC_W = (DECEL_PERIOD > 1) ? $clog2(DECEL_PERIOD) : 1;
  logic [FC_W-1:0] frame_cnt;
`endif

  function automatic obj_state_t obj_init(input int i);
    obj_state_t o;
    o.x  = POS_W'(INIT_X + i * INIT_STEP);
    o.y  = POS_W'(INIT_Y);
    o.vx = (i == 0) ? '0 : VEL_W'(INIT_VX);
    o.vy = (i == 0) ? '0 : VEL_W'(INIT_VY);
    return o;
  endfunction

  assign cur = obj[idx];

  ball_integrator #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .MAX_SPEED(MAX_SPEED),
    .DECEL    (DECEL)
  ) u_integrator (
    .cur     (cur),
    .coll_x  (coll_x_q),
    .coll_y  (coll_y_q),
    .player  (idx == '0),
    .button_u(button_u),
    .button_d(button_d),
    .button_l(button_l),
    .button_r(button_r),
`ifdef MULTI_BALL_FRICTION_EN
    .fric    (frame_cnt == '0),
`endif
    .nxt     (upd)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (frame_tick) state_nxt = S_LOOKUP;
      S_LOOKUP: state_nxt = (COLL_LAT > 0) ? S_WAIT : S_UPDATE;
      S_WAIT:   if (wait_cnt == 3'd1) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = (idx == LAST_IDX) ? S_DONE : S_LOOKUP;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    coll_addr = '0;
    if (state == S_LOOKUP || state == S_WAIT)
      coll_addr = ADDR_W'(cur.y) * ADDR_W'(SCREEN_W) + ADDR_W'(cur.x);
  end

  assign busy          = (state == S_LOOKUP) || (state == S_WAIT) || (state == S_UPDATE);
  assign update_done   = (state == S_DONE);
  assign frame_overrun = frame_tick && (state != S_IDLE);

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      wait_cnt <= '0;
      coll_x_q <= 1'b0;
      coll_y_q <= 1'b0;
      for (int i = 0; i < N_OBJ; i++) obj[i] <= obj_init(i);
`ifdef MULTI_BALL_FRICTION_EN
      frame_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (frame_tick) begin
            idx <= '0;
`ifdef MULTI_BALL_FRICTION_EN
            frame_cnt <= (frame_cnt == FC_W'(DECEL_PERIOD - 1)) ? '0 : frame_cnt + 1'b1;
`endif
          end
        end
        S_LOOKUP: begin
          wait_cnt <= 3'(COLL_LAT);
          if (COLL_LAT == 0) begin
            coll_x_q <= coll_x;
            coll_y_q <= coll_y;
          end
        end
        // Map data is valid on the final latency cycle.
        S_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            coll_x_q <= coll_x;
            coll_y_q <= coll_y;
          end
        end
        S_UPDATE: begin
          obj[idx] <= upd;
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_OBJ; g++) begin : g_flat
    assign obj_x[g*POS_W +: POS_W] = obj[g].x;
    assign obj_y[g*POS_W +: POS_W] = obj[g].y;
  end

endmodule

// File: tb/tb_multi_ball_physics.sv
// Directed bench for multi_ball_physics with default parameters (N_OBJ=4, COLL_LAT=1).
// Friction scenario runs only when MULTI_BALL_FRICTION_EN is defined.
module tb_multi_ball_physics;

  localparam int POS_W = 10;

  logic        pixel_clk = 1'b0;
  logic        rst, frame_tick;
  logic        button_u, button_d, button_l, button_r;
  logic        coll_x, coll_y;
  logic [18:0] coll_addr;
  logic [39:0] obj_x, obj_y;
  logic        busy, update_done, frame_overrun;

  logic        cx_en, cy_en;
  logic [18:0] cx_addr, cy_addr;
  int          n_pass = 0;
  int          n_total = 0;
  int          done_cnt = 0;
  int          ovr_cnt = 0;

  multi_ball_physics dut (
    .pixel_clk    (pixel_clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .button_u     (button_u),
    .button_d     (button_d),
    .button_l     (button_l),
    .button_r     (button_r),
    .coll_addr    (coll_addr),
    .coll_x       (coll_x),
    .coll_y       (coll_y),
    .obj_x        (obj_x),
    .obj_y        (obj_y),
    .busy         (busy),
    .update_done  (update_done),
    .frame_overrun(frame_overrun)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Collision map: flags one chosen address per axis.
  assign coll_x = cx_en && (coll_addr == cx_addr);
  assign coll_y = cy_en && (coll_addr == cy_addr);

  always @(negedge pixel_clk) begin
    if (update_done) done_cnt <= done_cnt + 1;
    if (frame_overrun) ovr_cnt <= ovr_cnt + 1;
  end

  function automatic logic [9:0] gx(input int i);
    return obj_x[i*POS_W +: POS_W];
  endfunction

  function automatic logic [9:0] gy(input int i);
    return obj_y[i*POS_W +: POS_W];
  endfunction

  task automatic do_reset();
    rst = 1'b1; frame_tick = 1'b0;
    button_u = 1'b0; button_d = 1'b0; button_l = 1'b0; button_r = 1'b0;
    cx_en = 1'b0; cy_en = 1'b0; cx_addr = '0; cy_addr = '0;
    @(posedge pixel_clk); @(posedge pixel_clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_frame(output int lat);
    @(posedge pixel_clk); #1;
    frame_tick = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge pixel_clk); #1;
      if (k == 1) frame_tick = 1'b0;
      if (update_done) begin lat = k; break; end
    end
    if (lat == 0) begin
      n_total++;
      $display("FAIL frame_timeout got no update_done within 40 cycles");
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (gx(0) !== 10'd200) $display("FAIL reset_x0 got %0d want 200", gx(0)); else n_pass++;
    n_total++; if (gy(0) !== 10'd300) $display("FAIL reset_y0 got %0d want 300", gy(0)); else n_pass++;
    n_total++; if (gx(1) !== 10'd240) $display("FAIL reset_x1 got %0d want 240", gx(1)); else n_pass++;
    n_total++; if (gx(3) !== 10'd320) $display("FAIL reset_x3 got %0d want 320", gx(3)); else n_pass++;
    n_total++; if (gy(3) !== 10'd300) $display("FAIL reset_y3 got %0d want 300", gy(3)); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
    n_total++; if (update_done !== 1'b0) $display("FAIL reset_done got %0b want 0", update_done); else n_pass++;
    n_total++; if (frame_overrun !== 1'b0) $display("FAIL reset_ovr got %0b want 0", frame_overrun); else n_pass++;
    n_total++; if (coll_addr !== 19'd0) $display("FAIL reset_addr got %0d want 0", coll_addr); else n_pass++;
  endtask

  // Walk timing, per-object write timing and overrun on a re-tick 3 cycles after accept.
  task automatic test_back_to_back();
    int first_done;
    do_reset();
    done_cnt = 0; ovr_cnt = 0; first_done = 0;
    @(posedge pixel_clk); #1;
    frame_tick = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge pixel_clk); #1;
      if (k == 1) frame_tick = 1'b0;
      if (k == 3) frame_tick = 1'b1;
      if (k == 4) frame_tick = 1'b0;
      if (k == 1) begin
        n_total++; if (busy !== 1'b1) $display("FAIL walk_busy got %0b want 1", busy); else n_pass++;
      end
      if (k == 6) begin
        n_total++; if (gx(1) !== 10'd240) $display("FAIL obj1_early got %0d want 240", gx(1)); else n_pass++;
      end
      if (k == 7) begin
        n_total++; if (gx(1) !== 10'd242) $display("FAIL obj1_write got %0d want 242", gx(1)); else n_pass++;
      end
      if (k == 12) begin
        n_total++; if (gx(3) !== 10'd320) $display("FAIL obj3_early got %0d want 320", gx(3)); else n_pass++;
      end
      if (k == 13) begin
        n_total++; if (gx(3) !== 10'd322) $display("FAIL obj3_write got %0d want 322", gx(3)); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL done_busy got %0b want 0", busy); else n_pass++;
      end
      if (update_done && first_done == 0) first_done = k;
    end
    n_total++; if (first_done != 13) $display("FAIL done_latency got %0d want 13", first_done); else n_pass++;
    n_total++; if (ovr_cnt != 1) $display("FAIL overrun_count got %0d want 1", ovr_cnt); else n_pass++;
    n_total++; if (done_cnt != 1) $display("FAIL done_count got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_collision();
    int lat;
    do_reset();
    cx_addr = 19'd240240; cx_en = 1'b1;
    cy_addr = 19'd240280; cy_en = 1'b1;
    run_frame(lat);
    cx_en = 1'b0; cy_en = 1'b0;
    n_total++; if (lat != 13) $display("FAIL coll_latency got %0d want 13", lat); else n_pass++;
    n_total++; if (gx(1) !== 10'd238) $display("FAIL collx_x1 got %0d want 238", gx(1)); else n_pass++;
    n_total++; if (gy(1) !== 10'd301) $display("FAIL collx_y1 got %0d want 301", gy(1)); else n_pass++;
    n_total++; if (gx(2) !== 10'd282) $display("FAIL colly_x2 got %0d want 282", gx(2)); else n_pass++;
    n_total++; if (gy(2) !== 10'd299) $display("FAIL colly_y2 got %0d want 299", gy(2)); else n_pass++;
    n_total++; if (gx(0) !== 10'd200) $display("FAIL coll_x0 got %0d want 200", gx(0)); else n_pass++;
    run_frame(lat);
    n_total++; if (gx(1) !== 10'd236) $display("FAIL collx_keep got %0d want 236", gx(1)); else n_pass++;
    n_total++; if (gy(2) !== 10'd298) $display("FAIL colly_keep got %0d want 298", gy(2)); else n_pass++;
  endtask

  // Player accelerates with button_r; speed clamps at 10.
  task automatic test_button_r();
    int lat, exp_x, exp_v;
    do_reset();
    button_r = 1'b1;
    exp_x = 200; exp_v = 0;
    for (int f = 1; f <= 12; f++) begin
      run_frame(lat);
      exp_x = exp_x + exp_v;
      exp_v = (exp_v + 1 > 10) ? 10 : exp_v + 1;
      n_total++;
      if (gx(0) !== 10'(exp_x)) $display("FAIL btn_x0 frame %0d got %0d want %0d", f, gx(0), exp_x);
      else n_pass++;
    end
    button_r = 1'b0;
    n_total++; if (gx(0) !== 10'd265) $display("FAIL btn_final got %0d want 265", gx(0)); else n_pass++;
    n_total++; if (gy(0) !== 10'd300) $display("FAIL btn_y0 got %0d want 300", gy(0)); else n_pass++;
    n_total++; if (gx(1) !== 10'd264) $display("FAIL auto_x1 got %0d want 264", gx(1)); else n_pass++;
    n_total++; if (gy(1) !== 10'd312) $display("FAIL auto_y1 got %0d want 312", gy(1)); else n_pass++;
  endtask

  // Drive obj 0 into the right edge, then let it coast into the left edge.
  task automatic test_edge();
    int lat;
    do_reset();
    button_r = 1'b1;
    for (int f = 1; f <= 66; f++) begin
      run_frame(lat);
      if (f == 65) begin
        n_total++; if (gx(0) !== 10'd795) $display("FAIL edge_pre got %0d want 795", gx(0)); else n_pass++;
      end
    end
    n_total++; if (gx(0) !== 10'd799) $display("FAIL edge_sat_r got %0d want 799", gx(0)); else n_pass++;
    button_r = 1'b0;
    run_frame(lat);
    n_total++; if (gx(0) !== 10'd790) $display("FAIL edge_bounce_r got %0d want 790", gx(0)); else n_pass++;
    for (int f = 0; f < 87; f++) run_frame(lat);
    n_total++; if (gx(0) !== 10'd7) $display("FAIL edge_pre_l got %0d want 7", gx(0)); else n_pass++;
    run_frame(lat);
    n_total++; if (gx(0) !== 10'd0) $display("FAIL edge_sat_l got %0d want 0", gx(0)); else n_pass++;
    run_frame(lat);
    n_total++; if (gx(0) !== 10'd9) $display("FAIL edge_bounce_l got %0d want 9", gx(0)); else n_pass++;
  endtask

  task automatic test_reset_mid_walk();
    int lat;
    do_reset();
    for (int f = 0; f < 3; f++) run_frame(lat);
    n_total++; if (gx(1) !== 10'd246) $display("FAIL pre_abort_x1 got %0d want 246", gx(1)); else n_pass++;
    @(posedge pixel_clk); #1;
    frame_tick = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge pixel_clk); #1;
      if (k == 1) frame_tick = 1'b0;
    end
    rst = 1'b1;
    @(posedge pixel_clk); #1;
    rst = 1'b0;
    n_total++; if (gx(1) !== 10'd240) $display("FAIL abort_x1 got %0d want 240", gx(1)); else n_pass++;
    n_total++; if (gy(1) !== 10'd300) $display("FAIL abort_y1 got %0d want 300", gy(1)); else n_pass++;
    n_total++; if (gx(3) !== 10'd320) $display("FAIL abort_x3 got %0d want 320", gx(3)); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL abort_busy got %0b want 0", busy); else n_pass++;
    run_frame(lat);
    n_total++; if (lat != 13) $display("FAIL abort_latency got %0d want 13", lat); else n_pass++;
    n_total++; if (gx(1) !== 10'd242) $display("FAIL abort_resume got %0d want 242", gx(1)); else n_pass++;
  endtask

`ifdef MULTI_BALL_FRICTION_EN
  task automatic test_friction();
    int lat;
    do_reset();
    button_r = 1'b1;
    for (int f = 1; f <= 5; f++) run_frame(lat);
    button_r = 1'b0;
    n_total++; if (gx(0) !== 10'd210) $display("FAIL fric_x5 got %0d want 210", gx(0)); else n_pass++;
    run_frame(lat);
    n_total++; if (gx(0) !== 10'd214) $display("FAIL fric_x6 got %0d want 214", gx(0)); else n_pass++;
    for (int f = 7; f <= 11; f++) run_frame(lat);
    n_total++; if (gx(0) !== 10'd233) $display("FAIL fric_x11 got %0d want 233", gx(0)); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_collision();
    test_button_r();
    test_edge();
    test_reset_mid_walk();
`ifdef MULTI_BALL_FRICTION_EN
    test_friction();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
